// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction-fetch slice: state encoding, default sizing
// and instruction field helpers used by the fetch unit and its consumers.
package fetch_unit_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_WAIT_W   = 4;
  localparam int DEF_MAX_WAIT = 15;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    EXEC = 3'd3,
    ERR  = 3'd4
  } fetch_state_t;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rdest;
    logic [3:0] ext;
    logic [3:0] rsrc;
  } instr_fields_t;

  function automatic instr_fields_t decode_fields(input logic [15:0] instr);
    instr_fields_t f;
    f.opcode = instr[15:12];
    f.rdest  = instr[11:8];
    f.ext    = instr[7:4];
    f.rsrc   = instr[3:0];
    return f;
  endfunction

  function automatic logic [7:0] disp_of(input logic [15:0] instr);
    return instr[7:0];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus between the fetch unit and its environment (pc block, instruction memory,
// controller). The fetch unit takes the slave side.
interface fetch_unit_if #(parameter int DATA_W = 16);

  logic [DATA_W-1:0] pc;
  logic              stall;
  logic              flush;
  logic              exec_done;
  logic              mem_rdy;
  logic [DATA_W-1:0] mem_data;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] ir;
  logic              ir_valid;
  logic [7:0]        disp;
  logic              pcEn;
  logic              fetch_err;

  modport master (
    output pc, stall, flush, exec_done, mem_rdy, mem_data,
    input  mem_rd, mem_addr, ir, ir_valid, disp, pcEn, fetch_err
  );

  modport slave (
    input  pc, stall, flush, exec_done, mem_rdy, mem_data,
    output mem_rd, mem_addr, ir, ir_valid, disp, pcEn, fetch_err
  );

endinterface

// File: rtl/fetch_wait_timer.sv
// Counts WAIT cycles without mem_rdy; tc flags the cycle whose increment
// reaches MAX_WAIT, so the FSM can leave for ERR on that same edge.
module fetch_wait_timer #(
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [WAIT_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (clr) begin
      wait_cnt <= '0;
    end else if (en) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  assign tc = (wait_cnt == WAIT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: requests pc from instruction memory, latches the
// word into ir and pulses pcEn once the controller finishes executing it.
//
// state | meaning
// IDLE  | between instructions; pcEn high in the first cycle after EXEC
// REQ   | one cycle; mem_addr/wait counter load on exit
// WAIT  | mem_rd high, waiting for mem_rdy
// EXEC  | ir_valid high until exec_done
// ERR   | memory timeout, sticky until reset
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WAIT_W   = DEF_WAIT_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input logic         clk,
  input logic         rst,
  fetch_unit_if.slave bus
);

  fetch_state_t      state_q, state_d;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] mem_addr_q;
  logic              ir_valid_q;
  logic              mem_rd_q;
  logic              pc_en_q;
  logic              fetch_err_q;
  logic              ir_load;
  logic              addr_load;
  logic              pc_adv;
  logic              wait_tc;
  logic              wait_en;

  fetch_wait_timer #(
    .WAIT_W  (WAIT_W),
    .MAX_WAIT(MAX_WAIT)
  ) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(state_q == REQ),
    .en (wait_en),
    .tc (wait_tc)
  );

  assign wait_en = (state_q == WAIT) && !bus.mem_rdy && !bus.flush;

  always_comb begin
    state_d   = state_q;
    ir_load   = 1'b0;
    addr_load = 1'b0;
    pc_adv    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!bus.stall) state_d = REQ;
      end
      REQ: begin
        addr_load = 1'b1;
        if (!bus.flush) state_d = WAIT;
      end
      WAIT: begin
        // flush beats a same-cycle mem_rdy: the returned word is dropped
        if (bus.flush) begin
          state_d = REQ;
        end else if (bus.mem_rdy) begin
          state_d = EXEC;
          ir_load = 1'b1;
        end else if (wait_tc) begin
          state_d = ERR;
        end
      end
      EXEC: begin
        if (bus.exec_done) begin
          state_d = IDLE;
          pc_adv  = 1'b1;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      ir_q        <= '0;
      ir_valid_q  <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      pc_en_q     <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_rd_q    <= (state_d == WAIT);
      ir_valid_q  <= (state_d == EXEC);
      fetch_err_q <= fetch_err_q | (state_d == ERR);
      pc_en_q     <= pc_adv;
      if (addr_load) mem_addr_q <= bus.pc;
      if (ir_load)   ir_q       <= bus.mem_data;
    end
  end

  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.ir        = ir_q;
  assign bus.ir_valid  = ir_valid_q;
  assign bus.disp      = disp_of(ir_q[15:0]);
  assign bus.pcEn      = pc_en_q;
  assign bus.fetch_err = fetch_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, zero-wait loop, delayed memory,
// flush, timeout and stall/reset-mid-fetch scenarios.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.DATA_W(16)) bus ();

  fetch_unit dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_rise;
    int n_instr;
    int n_pcen;
    int n;
    logic prev_v;

    bus.pc        = 16'h0000;
    bus.stall     = 1'b1;
    bus.flush     = 1'b0;
    bus.exec_done = 1'b0;
    bus.mem_rdy   = 1'b1;
    bus.mem_data  = 16'h1234;

    // reset hold and first fetch
    repeat (3) tick();
    chk("rst_ir", bus.ir, 16'h0000);
    chk("rst_ir_valid", bus.ir_valid, 1'b0);
    chk("rst_mem_rd", bus.mem_rd, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 16'h0000);
    chk("rst_pcen", bus.pcEn, 1'b0);
    chk("rst_err", bus.fetch_err, 1'b0);
    chk("rst_disp", bus.disp, 8'h00);
    rst = 1'b1;
    bus.stall = 1'b0;
    tick();
    chk("t1_req_rd", bus.mem_rd, 1'b0);
    chk("t1_req_valid", bus.ir_valid, 1'b0);
    tick();
    chk("t1_wait_rd", bus.mem_rd, 1'b1);
    chk("t1_wait_addr", bus.mem_addr, 16'h0000);
    chk("t1_wait_valid", bus.ir_valid, 1'b0);
    tick();
    chk("t1_ir", bus.ir, 16'h1234);
    chk("t1_valid", bus.ir_valid, 1'b1);
    chk("t1_disp", bus.disp, 8'h34);
    chk("t1_exec_rd", bus.mem_rd, 1'b0);
    bus.exec_done = 1'b1;
    tick();
    bus.exec_done = 1'b0;
    chk("t1_pcen", bus.pcEn, 1'b1);
    chk("t1_valid_clr", bus.ir_valid, 1'b0);
    chk("t1_ir_hold", bus.ir, 16'h1234);
    tick();
    chk("t1_pcen_pulse", bus.pcEn, 1'b0);

    // zero-wait loop with pc loopback
    bus.pc = 16'h0000;
    bus.mem_rdy = 1'b1;
    do_reset();
    last_rise = -1;
    n_instr = 0;
    n_pcen = 0;
    prev_v = 1'b0;
    for (int cyc = 0; cyc < 13; cyc++) begin
      tick();
      if (bus.pcEn) begin
        n_pcen++;
        bus.pc = bus.pc + 16'h0001;
      end
      bus.mem_data = bus.mem_addr + 16'hA000;
      if (bus.ir_valid && !prev_v) begin
        chk("loop_ir", bus.ir, 16'hA000 + 16'(n_instr));
        if (last_rise >= 0) chk("loop_period", cyc - last_rise, 4);
        last_rise = cyc;
        n_instr++;
      end
      prev_v = bus.ir_valid;
      bus.exec_done = bus.ir_valid;
    end
    bus.exec_done = 1'b0;
    chk("loop_n_instr", n_instr, 3);
    chk("loop_n_pcen", n_pcen, 3);

    // memory answering on the 4th WAIT cycle
    bus.pc = 16'h8000;
    bus.mem_rdy = 1'b0;
    do_reset();
    tick();
    chk("dly_req_rd", bus.mem_rd, 1'b0);
    tick();
    bus.pc = 16'h1111;
    for (int i = 0; i < 4; i++) begin
      chk("dly_wait_rd", bus.mem_rd, 1'b1);
      chk("dly_wait_addr", bus.mem_addr, 16'h8000);
      chk("dly_wait_valid", bus.ir_valid, 1'b0);
      if (i == 3) begin
        bus.mem_rdy = 1'b1;
        bus.mem_data = 16'h5678;
      end
      tick();
    end
    chk("dly_ir", bus.ir, 16'h5678);
    chk("dly_valid", bus.ir_valid, 1'b1);
    chk("dly_exec_rd", bus.mem_rd, 1'b0);

    // flush together with mem_rdy
    bus.mem_rdy = 1'b0;
    bus.exec_done = 1'b1;
    tick();
    bus.exec_done = 1'b0;
    bus.pc = 16'h0042;
    tick();
    tick();
    chk("fl_wait_rd", bus.mem_rd, 1'b1);
    bus.mem_rdy = 1'b1;
    bus.mem_data = 16'hDEAD;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.mem_rdy = 1'b0;
    chk("fl_req_rd", bus.mem_rd, 1'b0);
    chk("fl_ir_hold", bus.ir, 16'h5678);
    chk("fl_valid", bus.ir_valid, 1'b0);
    tick();
    chk("fl_rewait_rd", bus.mem_rd, 1'b1);
    chk("fl_rewait_addr", bus.mem_addr, 16'h0042);
    bus.mem_rdy = 1'b1;
    bus.mem_data = 16'hBEEF;
    tick();
    bus.mem_rdy = 1'b0;
    chk("fl_ir", bus.ir, 16'hBEEF);
    chk("fl_valid_set", bus.ir_valid, 1'b1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("fl_exec_ignored", bus.ir_valid, 1'b1);
    chk("fl_exec_rd", bus.mem_rd, 1'b0);

    // memory timeout
    bus.exec_done = 1'b1;
    tick();
    bus.exec_done = 1'b0;
    bus.pc = 16'h0100;
    tick();
    tick();
    n = 0;
    while (bus.mem_rd && n < 40) begin
      n++;
      tick();
    end
    chk("to_wait_cycles", n, 15);
    chk("to_err", bus.fetch_err, 1'b1);
    chk("to_rd", bus.mem_rd, 1'b0);
    chk("to_valid", bus.ir_valid, 1'b0);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    bus.mem_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_err_sticky", bus.fetch_err, 1'b1);
      chk("to_err_rd", bus.mem_rd, 1'b0);
    end
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.mem_rdy = 1'b0;
    rst = 1'b0;
    tick();
    chk("to_rst_err", bus.fetch_err, 1'b0);
    chk("to_rst_addr", bus.mem_addr, 16'h0000);
    chk("to_rst_ir", bus.ir, 16'h0000);
    chk("to_rst_rd", bus.mem_rd, 1'b0);
    chk("to_rst_pcen", bus.pcEn, 1'b0);

    // stall after pcEn, then reset in the middle of WAIT
    bus.pc = 16'h0010;
    bus.mem_rdy = 1'b1;
    bus.mem_data = 16'h2222;
    rst = 1'b1;
    tick();
    tick();
    tick();
    chk("st_ir", bus.ir, 16'h2222);
    bus.stall = 1'b1;
    bus.exec_done = 1'b1;
    tick();
    bus.exec_done = 1'b0;
    chk("st_pcen", bus.pcEn, 1'b1);
    bus.pc = 16'h0011;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("st_hold_rd", bus.mem_rd, 1'b0);
      chk("st_hold_pcen", bus.pcEn, 1'b0);
    end
    bus.stall = 1'b0;
    tick();
    chk("st_req_rd", bus.mem_rd, 1'b0);
    tick();
    chk("st_wait_rd", bus.mem_rd, 1'b1);
    chk("st_wait_addr", bus.mem_addr, 16'h0011);
    bus.mem_data = 16'h3333;
    rst = 1'b0;
    tick();
    chk("mid_rst_ir", bus.ir, 16'h0000);
    chk("mid_rst_valid", bus.ir_valid, 1'b0);
    chk("mid_rst_rd", bus.mem_rd, 1'b0);
    rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the pc register and upstream of the decoder/datapath controller.
- Samples pc and issues a read to instruction memory, which has a variable-latency ready handshake.
- Latches the returned word into the instruction register (ir) and holds it while the instruction executes.
- Produces the single-cycle pcEn pulse that advances the pc once execution completes, so the pc and fetch loop stay in lockstep.

Parameters:
- DATA_W, 16, instruction/address width.
- WAIT_W, 4, width of the memory-wait counter.
- MAX_WAIT, 15, cycles in WAIT without mem_rdy before fetch_err is raised; must be < 2**WAIT_W.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset.
- pc  in  DATA_W  current program counter from the pc block.
- stall  in  1  holds the fetch loop in IDLE while high.
- flush  in  1  aborts the in-flight fetch and re-requests from the current pc.
- exec_done  in  1  controller signals that the current ir has finished executing.
- mem_rdy  in  1  instruction memory data valid.
- mem_data  in  DATA_W  instruction memory read data.
- mem_rd  out  1  read request to instruction memory.
- mem_addr  out  DATA_W  read address, registered.
- ir  out  DATA_W  instruction register.
- ir_valid  out  1  ir holds an instruction currently executing.
- disp  out  8  ir[7:0], branch displacement to the pc block.
- pcEn  out  1  one-cycle pc advance pulse, registered.
- fetch_err  out  1  sticky memory timeout flag.

Behaviour:
- Reset: rst sampled low at posedge. Next cycle state=IDLE, ir=0, ir_valid=0, pcEn=0, mem_rd=0, mem_addr=0, fetch_err=0, wait_cnt=0. Reset mid-fetch abandons the request with no ir update.
- States: IDLE, REQ, WAIT, EXEC, ERR. All outputs come from registers; disp=ir[7:0] combinationally.
- IDLE:
  - stall=0 -> REQ.
  - stall=1 -> stay in IDLE.
  - pcEn is high only in the first IDLE cycle following EXEC.
- REQ: one cycle.
  - Edge leaving REQ loads mem_addr<=pc and wait_cnt<=0.
  - Always -> WAIT.
  - mem_rdy is ignored in REQ.
- WAIT:
  - mem_rd=1 and mem_addr held stable.
  - mem_rdy=1 -> ir<=mem_data, ir_valid<=1, go to EXEC.
  - Otherwise wait_cnt increments; wait_cnt==MAX_WAIT with no mem_rdy -> ERR.
- EXEC:
  - mem_rd=0, ir_valid=1.
  - exec_done=1 -> ir_valid<=0, pcEn<=1, go to IDLE.
  - ir is retained after exec_done until the next successful fetch.
- Latency:
  - Minimum fetch latency: ir_valid rises 2 cycles after leaving IDLE (REQ, then WAIT with mem_rdy=1).
  - Steady-state loop with zero-wait memory and exec_done asserted immediately: 4 cycles per instruction.
- pc handshake: pcEn is high during IDLE, so the pc updates at the end of that cycle. The following REQ therefore always samples the new pc. IDLE lasts at least one cycle after EXEC, even with stall=0.
- flush:
  - In REQ or WAIT -> go to REQ next cycle, mem_rd=0 that cycle, ir/ir_valid unchanged.
  - flush and mem_rdy in the same cycle: flush wins and mem_data is discarded.
  - flush in IDLE, EXEC or ERR is ignored.
- ERR: mem_rd=0, ir_valid=0, fetch_err=1. Exits only on reset.
- stall in WAIT/EXEC has no effect; it gates only IDLE->REQ.
- exec_done outside EXEC is ignored.

Decomposition:
- Shared package/defines:
  - State encodings (3 bits): IDLE=0, REQ=1, WAIT=2, EXEC=3, ERR=4.
  - Instruction field slices: opcode [15:12], rdest [11:8], ext [7:4], rsrc [3:0], imm/disp [7:0].
- One sub-module is natural: fetch_wait_timer (wait_cnt with clear/enable and terminal-count output, MAX_WAIT compare).
- Everything else stays in fetch_unit.

Test Plan:
- Reset hold, then release with stall=0, mem_rdy=1 in WAIT, pc=16'h0000, mem_data=16'h1234 -> ir=16'h1234, ir_valid high 2 cycles after IDLE, mem_addr=16'h0000, disp=8'h34.
- Connect the pc block (pcEn loopback), zero-wait memory returning addr+16'hA000, exec_done=1 whenever ir_valid=1 -> ir sequence A000, A001, A002…; one pcEn pulse per instruction; 4-cycle period.
- Memory delays mem_rdy 3 cycles, address 16'h8000 -> mem_rd high for 4 WAIT cycles, mem_addr stable at 16'h8000, ir loads on the 4th.
- flush asserted together with mem_rdy (mem_data=16'hDEAD) -> ir unchanged, state back to REQ, next fetch returns the correct word.
- No mem_rdy for 15 WAIT cycles -> fetch_err=1, mem_rd=0, state stays ERR despite stall/flush. Drive rst low -> all outputs return to reset values.
- stall=1 held 5 cycles after pcEn -> no mem_rd. Drop stall -> REQ next cycle using the updated pc. Reset mid-WAIT -> ir_valid=0, ir=0, mem_rd=0.
